// File: rtl/snake_pkg.sv
// Shared definitions for the snake game speed scheduler.
// State encodings are also consumed by the game FSM and the debug LEDs.
package snake_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2,
      OVER   = 2'd3
   } speed_state_t;

   function automatic logic can_start(speed_state_t s);
      return (s == IDLE) || (s == OVER);
   endfunction

endpackage

// File: rtl/snake_frame_div.sv
// Frame divider: counts frame_start pulses and emits a registered tick every `period` frames.
// The >= compare lets a shortened period take effect without wrap or missed ticks.
module snake_frame_div #(
   parameter int FRAME_W = 6
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic               en,
   input  logic               frame_start,
   input  logic [FRAME_W-1:0] period,
   output logic               tick
);

   logic [FRAME_W-1:0] frame_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         frame_cnt <= '0;
         tick      <= 1'b0;
      end else begin
         tick <= 1'b0;
         if (clear) begin
            frame_cnt <= '0;
         end else if (en && frame_start) begin
            if (frame_cnt >= period - FRAME_W'(1)) begin
               frame_cnt <= '0;
               tick      <= 1'b1;
            end else begin
               frame_cnt <= frame_cnt + FRAME_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/snake_speed_ctrl.sv
// Game-speed scheduler: run/pause/over FSM, food-driven level, period and move_tick generation.
// Optional SNAKE_SPEED_BOOST_EN adds a `boost` input that halves the effective period in RUN.
module snake_speed_ctrl
   import snake_pkg::*;
#(
   parameter int FRAME_W        = 6,
   parameter int LEVEL_W        = 4,
   parameter int BASE_PERIOD    = 12,
   parameter int STEP           = 1,
   parameter int MIN_PERIOD     = 3,
   parameter int MAX_LEVEL      = 9,
   parameter int FOOD_PER_LEVEL = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               frame_start,
   input  logic               start,
   input  logic               pause,
   input  logic               food_eaten,
   input  logic               game_over,
`ifdef SNAKE_SPEED_BOOST_EN
   input  logic               boost,
`endif
   output logic               move_tick,
   output logic [LEVEL_W-1:0] level,
   output logic [FRAME_W-1:0] period,
   output logic               running
);

   localparam int PW     = FRAME_W + LEVEL_W;
   localparam int FOOD_W = (FOOD_PER_LEVEL > 1) ? $clog2(FOOD_PER_LEVEL) : 1;

   speed_state_t       state, state_next;
   logic               pause_d, pause_rise;
   logic               clear, div_en;
   logic [FOOD_W-1:0]  food_cnt;
   logic [PW-1:0]      prod;
   logic [FRAME_W-1:0] base_period, eff_period;

   assign pause_rise = pause & ~pause_d;

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (game_over) state_next = OVER;
                  else if (pause_rise) state_next = PAUSED;
         PAUSED:  if (game_over) state_next = OVER;
                  else if (pause_rise) state_next = RUN;
         OVER:    if (start) state_next = RUN;
         default: state_next = IDLE;
      endcase
   end

   assign clear  = can_start(state) && start;
   // Counting only while staying in RUN keeps ticks from surfacing in PAUSED/OVER.
   assign div_en = (state == RUN) && (state_next == RUN);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         pause_d  <= 1'b0;
         running  <= 1'b0;
         food_cnt <= '0;
         level    <= '0;
      end else begin
         state   <= state_next;
         pause_d <= pause;
         running <= (state_next == RUN);
         if (clear) begin
            food_cnt <= '0;
            level    <= '0;
         end else if ((state == RUN) && food_eaten) begin
            if (food_cnt == FOOD_W'(FOOD_PER_LEVEL - 1)) begin
               food_cnt <= '0;
               if (level != LEVEL_W'(MAX_LEVEL))
                  level <= level + LEVEL_W'(1);
            end else begin
               food_cnt <= food_cnt + FOOD_W'(1);
            end
         end
      end
   end

   always_comb begin
      prod = PW'(level) * PW'(STEP);
      if (prod >= PW'(BASE_PERIOD - MIN_PERIOD))
         base_period = FRAME_W'(MIN_PERIOD);
      else
         base_period = FRAME_W'(PW'(BASE_PERIOD) - prod);
   end

`ifdef SNAKE_SPEED_BOOST_EN
   always_comb begin
      eff_period = base_period;
      if (boost && (state == RUN)) begin
         eff_period = base_period >> 1;
         if (eff_period == '0)
            eff_period = FRAME_W'(1);
      end
   end
`else
   assign eff_period = base_period;
`endif

   assign period = eff_period;

   snake_frame_div #(
      .FRAME_W (FRAME_W)
   ) u_div (
      .clk         (clk),
      .reset       (reset),
      .clear       (clear),
      .en          (div_en),
      .frame_start (frame_start),
      .period      (eff_period),
      .tick        (move_tick)
   );

endmodule

// File: tb/tb_snake_speed_ctrl.sv
// Directed self-checking bench for snake_speed_ctrl (default build, no boost).
module tb_snake_speed_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       frame_start = 1'b0;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic       food_eaten = 1'b0;
   logic       game_over = 1'b0;
   logic       move_tick;
   logic [3:0] level;
   logic [5:0] period;
   logic       running;

   int compared = 0;
   int mismatched = 0;
   int ticks = 0;
   logic last_tick = 1'b0;

   always #5 clk = ~clk;

   snake_speed_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .frame_start (frame_start),
      .start       (start),
      .pause       (pause),
      .food_eaten  (food_eaten),
      .game_over   (game_over),
      .move_tick   (move_tick),
      .level       (level),
      .period      (period),
      .running     (running)
   );

   task automatic step();
      @(posedge clk);
      #1;
      ticks += int'(move_tick);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic frame();
      frame_start = 1'b1;
      step();
      last_tick = move_tick;
      frame_start = 1'b0;
      step();
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) frame();
   endtask

   task automatic food(input int n);
      for (int i = 0; i < n; i++) begin
         food_eaten = 1'b1;
         step();
         food_eaten = 1'b0;
         step();
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
      step();
   endtask

   task automatic pulse_over();
      game_over = 1'b1;
      step();
      game_over = 1'b0;
      step();
   endtask

   initial begin
      // 1: reset values, then 24 frames give exactly two ticks
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rst_level", 32'(level), 0);
      chk("rst_period", 32'(period), 12);
      chk("rst_running", 32'(running), 0);
      chk("rst_tick", 32'(move_tick), 0);
      pulse_start();
      chk("t1_running", 32'(running), 1);
      ticks = 0;
      frames(11);
      chk("t1_no_tick_11", 32'(ticks), 0);
      frame();
      chk("t1_tick_12", 32'(last_tick), 1);
      frames(11);
      chk("t1_ticks_23", 32'(ticks), 1);
      frame();
      chk("t1_tick_24", 32'(last_tick), 1);
      chk("t1_ticks_24", 32'(ticks), 2);

      // 2: level progression and saturation
      food(4);
      chk("t2_level1", 32'(level), 1);
      chk("t2_period11", 32'(period), 11);
      food(36);
      chk("t2_level9", 32'(level), 9);
      chk("t2_period3", 32'(period), 3);
      food(4);
      chk("t2_level_sat", 32'(level), 9);
      chk("t2_period_sat", 32'(period), 3);
      pulse_over();
      chk("t2_over_running", 32'(running), 0);
      pulse_start();
      chk("t2_restart_level", 32'(level), 0);
      chk("t2_restart_period", 32'(period), 12);

      // 3: pause retains frame count, held pause does not re-toggle
      ticks = 0;
      frames(5);
      pause = 1'b1;
      step();
      chk("t3_paused", 32'(running), 0);
      frames(10);
      chk("t3_no_tick_paused", 32'(ticks), 0);
      chk("t3_still_paused", 32'(running), 0);
      pause = 1'b0;
      step();
      pause = 1'b1;
      step();
      chk("t3_resumed", 32'(running), 1);
      pause = 1'b0;
      frames(6);
      chk("t3_no_tick_6", 32'(ticks), 0);
      frame();
      chk("t3_tick_7", 32'(last_tick), 1);

      // 4: period shrinks below the current count -> immediate tick, no wrap
      pulse_over();
      pulse_start();
      ticks = 0;
      frames(10);
      food(7);
      chk("t4_level1", 32'(level), 1);
      food(1);
      chk("t4_level2", 32'(level), 2);
      chk("t4_period10", 32'(period), 10);
      frame();
      chk("t4_tick", 32'(last_tick), 1);
      frames(9);
      chk("t4_ticks_after9", 32'(ticks), 1);
      frame();
      chk("t4_tick_period10", 32'(last_tick), 1);

      // 5: game_over on the terminal frame suppresses the tick
      pulse_over();
      pulse_start();
      ticks = 0;
      frames(11);
      frame_start = 1'b1;
      game_over = 1'b1;
      step();
      chk("t5_no_tick", 32'(move_tick), 0);
      chk("t5_over", 32'(running), 0);
      frame_start = 1'b0;
      game_over = 1'b0;
      step();
      chk("t5_ticks", 32'(ticks), 0);
      pulse_start();
      chk("t5_level0", 32'(level), 0);
      chk("t5_running", 32'(running), 1);
      frames(11);
      chk("t5_cnt_cleared", 32'(ticks), 0);
      frame();
      chk("t5_tick_12", 32'(last_tick), 1);

      // 6: reset wins over a terminal frame and a food pulse
      food(5);
      chk("t6_level1", 32'(level), 1);
      frames(10);
      reset = 1'b1;
      frame_start = 1'b1;
      food_eaten = 1'b1;
      step();
      reset = 1'b0;
      frame_start = 1'b0;
      food_eaten = 1'b0;
      chk("t6_tick", 32'(move_tick), 0);
      chk("t6_level", 32'(level), 0);
      chk("t6_period", 32'(period), 12);
      chk("t6_running", 32'(running), 0);
      ticks = 0;
      frames(15);
      chk("t6_idle_no_tick", 32'(ticks), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
